computer_player: RTL and testbench

- Automated opponent for player-vs-computer Tug of War.
- Drives the "computer" side of the light chain: produces button-press pulses on the same one-cycle press interface that the light cells consume as L/R.
- Press decisions come from a pseudo-random LFSR compared against a switch-selected difficulty threshold.
- Sits between the difficulty switches and the input of the playfield light chain; its output replaces a synchronised human key.

---
 rtl/computer_player.sv | 109 ++++++++++
 tb/tb_computer_player.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/computer_player.sv
// Automated Tug of War opponent: an LFSR compared against a difficulty threshold yields one-cycle presses.
// Optional macro COMPUTER_PLAYER_COUNT_EN adds an 8-bit saturating press_count output.
module computer_player #(
  parameter int LFSR_W       = 10,
  parameter int TICK_DIV     = 16,
  parameter int COOLDOWN_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  output logic              press,
  output logic              busy,
`ifdef COMPUTER_PLAYER_COUNT_EN
  output logic [7:0]        press_count,
`endif
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS, COOLDOWN} state_t;

  state_t            state;
  logic [TW-1:0]     cnt;
  logic [CW-1:0]     cool;
  logic              tick;
  logic [LFSR_W-1:0] lfsr_next;

  assign tick = enable && (cnt == TICK_LAST);

  // The all-zero lock-up state is recovered to 1 in case it is ever reached.
  always_comb begin
    lfsr_next = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-4]};
    if (lfsr_q == '0) lfsr_next = {{(LFSR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= {{(LFSR_W-1){1'b0}}, 1'b1};
      cnt    <= '0;
      cool   <= '0;
      state  <= IDLE;
      press  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (enable) begin
        lfsr_q <= lfsr_next;
        cnt    <= (cnt == TICK_LAST) ? '0 : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (!enable) begin
        state <= IDLE;
        press <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            press <= 1'b0;
            busy  <= 1'b0;
            if (tick && (lfsr_q < difficulty)) begin
              state <= PRESS;
              press <= 1'b1;
              busy  <= 1'b1;
            end
          end
          PRESS: begin
            state <= COOLDOWN;
            cool  <= COOL_LOAD;
            press <= 1'b0;
            busy  <= 1'b1;
          end
          COOLDOWN: begin
            press <= 1'b0;
            if (cool == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cool <= cool - 1'b1;
              busy <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            press <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef COMPUTER_PLAYER_COUNT_EN
  // Counts completed press cycles even if enable dropped during the press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_count <= '0;
    end else if (press && (press_count != 8'hFF)) begin
      press_count <= press_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_computer_player.sv
// Directed self-checking bench for computer_player (TICK_DIV=4, COOLDOWN_CYC=4, LFSR_W=10).
module tb_computer_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] difficulty = '0;
  logic       press;
  logic       busy;
  logic [9:0] lfsr_q;
`ifdef COMPUTER_PLAYER_COUNT_EN
  logic [7:0] press_count;
`endif

  int errors = 0;
  int checks = 0;

  computer_player #(.LFSR_W(10), .TICK_DIV(4), .COOLDOWN_CYC(4)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .difficulty(difficulty),
    .press(press),
    .busy(busy),
`ifdef COMPUTER_PLAYER_COUNT_EN
    .press_count(press_count),
`endif
    .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in cycle 0: reset just released, lfsr_q = 001, cnt = 0.
  task automatic restart(input logic [9:0] diff, input logic en);
    @(posedge clk);
    #1;
    reset = 1'b1;
    difficulty = diff;
    enable = en;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [9:0] model_next(input logic [9:0] m);
    logic [9:0] n;
    n = {m[8:0], m[9] ^ m[6]};
    if (m == 10'h000) n = 10'h001;
    return n;
  endfunction

  task automatic test_reset();
    logic [9:0] exp_seq [4];
    exp_seq = '{10'h002, 10'h004, 10'h008, 10'h010};
    restart(10'h3FF, 1'b1);
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if (press !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pre_press: press=%b expected 1", press);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (press !== 1'b0 || busy !== 1'b0 || lfsr_q !== 10'h001) begin
      errors++;
      $display("[TB] FAIL reset_async: press=%b busy=%b lfsr=%h expected 0 0 001", press, busy, lfsr_q);
    end
    step();
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (lfsr_q !== exp_seq[i]) begin
        errors++;
        $display("[TB] FAIL reset_lfsr_seq%0d: lfsr=%h expected %h", i, lfsr_q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_zero_difficulty();
    int seen_press;
    int seen_busy;
    seen_press = 0;
    seen_busy = 0;
    restart(10'h000, 1'b1);
    for (int c = 1; c <= 500; c++) begin
      step();
      if (press === 1'b1) seen_press++;
      if (busy === 1'b1) seen_busy++;
    end
    checks++;
    if (seen_press !== 0 || seen_busy !== 0) begin
      errors++;
      $display("[TB] FAIL zero_difficulty: press cycles=%0d busy cycles=%0d expected 0 0", seen_press, seen_busy);
    end
  endtask

  task automatic test_max_difficulty();
    logic exp_press;
    logic exp_busy;
    restart(10'h3FF, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_press = (c == 4) || (c == 12);
      exp_busy = (c >= 4 && c <= 8) || (c >= 12);
      checks++;
      if (press !== exp_press || busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL max_diff_cycle%0d: press=%b busy=%b expected %b %b", c, press, busy, exp_press, exp_busy);
      end
      if (c == 3) begin
        checks++;
        if (lfsr_q !== 10'h008) begin
          errors++;
          $display("[TB] FAIL max_diff_tick_lfsr: lfsr=%h expected 008", lfsr_q);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    restart(10'h3FF, 1'b1);
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if (press !== 1'b1 || lfsr_q !== 10'h010) begin
      errors++;
      $display("[TB] FAIL drop_press_cycle: press=%b lfsr=%h expected 1 010", press, lfsr_q);
    end
    enable = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      step();
      checks++;
      if (press !== 1'b0 || busy !== 1'b0 || lfsr_q !== 10'h010) begin
        errors++;
        $display("[TB] FAIL drop_frozen_cycle%0d: press=%b busy=%b lfsr=%h expected 0 0 010", c, press, busy, lfsr_q);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (press !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL reenable_k%0d: press=%b expected %b", k, press, (k == 4));
      end
    end
  endtask

  task automatic test_period();
    logic [9:0] m;
    logic       skip;
    int         exp_presses;
    int         got_presses;
    int         first_return;
    m = 10'h001;
    skip = 1'b0;
    exp_presses = 0;
    got_presses = 0;
    first_return = -1;
    restart(10'h200, 1'b1);
    for (int c = 0; c < 4092; c++) begin
      // After a press, the next tick falls inside cooldown and is lost.
      if ((c % 4) == 3) begin
        if (skip) skip = 1'b0;
        else if (m < 10'h200) begin
          exp_presses++;
          skip = 1'b1;
        end
      end
      m = model_next(m);
      step();
      if (press === 1'b1) got_presses++;
      if (lfsr_q === 10'h001 && first_return < 0) first_return = c + 1;
    end
    checks++;
    if (first_return !== 1023 || lfsr_q !== 10'h001) begin
      errors++;
      $display("[TB] FAIL lfsr_period: first return=%0d final lfsr=%h expected 1023 001", first_return, lfsr_q);
    end
    checks++;
    if (got_presses !== exp_presses) begin
      errors++;
      $display("[TB] FAIL period_presses: got=%0d expected %0d", got_presses, exp_presses);
    end
    checks++;
    if (got_presses < 250 || got_presses > 512) begin
      errors++;
      $display("[TB] FAIL period_press_range: got=%0d expected 250..512", got_presses);
    end
  endtask

`ifdef COMPUTER_PLAYER_COUNT_EN
  task automatic test_count();
    restart(10'h3FF, 1'b1);
    for (int c = 1; c <= 3000; c++) step();
    checks++;
    if (press_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL count_saturate: press_count=%0d expected 255", press_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL count_reset: press_count=%0d expected 0", press_count);
    end
    step();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_difficulty();
    test_max_difficulty();
    test_enable_drop();
    test_period();
`ifdef COMPUTER_PLAYER_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
